life_monitor: RTL and testbench
===============================

# life_monitor

Row-serial statistics engine sitting directly downstream of the 16x16 toroidal Game-of-Life core. On a `sample` strobe it snapshots the core's `q` bus and scans it one row per cycle. It then reports the live-cell population, extinction, still-life and period-2 oscillation status, and a generation count. Supervisory logic and the test bench read these results instead of decoding the 256-bit grid themselves.

## Interface
- `W`, 16, grid width in cells (row length).
- `H`, 16, grid height in rows.
- `GEN_W`, 16, width of the generation counter.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  the same load strobe driven into the Life core; clears history and aborts any scan.
- `q`  in  W*H  grid from the Life core; row r = `q[r*W +: W]`, cell c = bit c of that row.
- `sample`  in  1  capture-and-scan request.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse; result outputs are updated in this cycle.
- `population`  out  $clog2(W*H+1)  live-cell count of the last completed scan.
- `extinct`  out  1  `population == 0`.
- `still`  out  1  snapshot equals the previous completed snapshot.
- `osc2`  out  1  snapshot equals the one from two scans ago and differs from the previous one.
- `overrun`  out  1  sticky flag: a `sample` arrived while `busy`.
- `gen_count`  out  GEN_W  number of accepted samples since `reset`/`load`; saturates at all-ones.
- `bbox_rmin`, `bbox_rmax`  out  $clog2(H)  bounding-box rows.
- `bbox_cmin`, `bbox_cmax`  out  $clog2(W)  bounding-box columns.

## Operation
- States: IDLE, SCAN. Row counter `row` in 0..H-1.
- IDLE with `sample=1`:
  - capture `snap <= q`;
  - `row <= 0`;
  - `gen_count` increments, saturating;
  - go to SCAN.
- SCAN cycle on row r:
  - accumulator += popcount(`snap` row r);
  - `eq1 &= (row r == prev1 row r)`;
  - `eq2 &= (row r == prev2 row r)`.
  - Accumulator, `eq1` and `eq2` are initialised at capture.
- On the edge that finishes row H-1:
  - register `population`, `extinct`, `still`, `osc2` and the bbox outputs;
  - shift history: `prev2 <= prev1`, `prev1 <= snap`;
  - `hist` (0..2, saturating) increments;
  - `done <= 1`;
  - go to IDLE.
- `still = eq1 && hist>=1` and `osc2 = eq2 && !eq1 && hist>=2`, both evaluated with `hist` before the increment.
- `sample` in SCAN: ignored and `overrun <= 1`. `overrun` clears only on `reset`.
- `load=1` (any state):
  - `hist <= 0`, `gen_count <= 0`;
  - SCAN aborts to IDLE with no `done` pulse;
  - result outputs hold their last values;
  - a `sample` in the same cycle is ignored.
- `reset=1`: every output and register goes to 0, state IDLE. Applies mid-scan as well.

## Timing
- `sample` accepted at edge k:
  - `busy=1` for the H cycles following edges k..k+H-1;
  - `done=1` and results valid in the cycle after edge k+H, so latency is H+1 = 17 edges.
- `busy` is low during the `done` cycle. A `sample` in that cycle is accepted, giving a back-to-back period of H+1 cycles.
- `q` is read only at the capture edge. The Life core may keep advancing during the scan.
- Results and `gen_count` hold between scans. `done` is never asserted for two consecutive cycles.

## Configuration
- `LIFE_MONITOR_BBOX_EN` defined:
  - during SCAN, track the min/max index of rows with any live cell and the OR of all rows;
  - the column min/max come from that OR mask;
  - registered together with `population`.
  - If the grid is empty, all bbox outputs are 0.
- Not defined: no bbox logic is built and the four bbox ports are tied to 0.

## Test plan
- Glider `q=256'h000200010007`, sample once:
  - `done` 17 edges later;
  - `population=5`, `extinct=0`, `still=0`, `osc2=0`, `gen_count=1`;
  - with BBOX: rows 0..2, cols 0..2.
- 2x2 block (`q=256'h00030003`) sampled twice: second `done` gives `still=1`, `population=4`.
- Blinker alternating `256'h0007` / `256'h00020002_0002`, three samples: third result `osc2=1`, `still=0`, `population=3`.
- `q=0` sampled twice: `extinct=1` on both results; `still=1` on the second.
- `sample` re-asserted 5 cycles into a scan:
  - `overrun=1`;
  - only one `done`;
  - `gen_count` increments by 1.
- `load` pulsed 8 cycles into a scan: no `done` follows, `gen_count=0`, `hist` cleared (next two identical samples give `still=0`, then `still=1`).

Source files
------------

// File: rtl/life_monitor_if.sv
// -----------------------------------------------------------------------------
// life_monitor_if
//   Bundle between the Life-core side (master) and the statistics engine
//   (slave). The master drives the load strobe, the grid and the sample
//   request. The slave returns busy/done and the registered scan results.
//
//   Parameters : W (row length), H (rows), GEN_W (generation counter width)
//   master     : drives load, q, sample; reads every result signal
//   slave      : reads load, q, sample; drives every result signal
// -----------------------------------------------------------------------------
interface life_monitor_if #(
  parameter int W     = 16,
  parameter int H     = 16,
  parameter int GEN_W = 16
);
  localparam int POP_W = $clog2(W * H + 1);
  localparam int RW    = $clog2(H);
  localparam int CW    = $clog2(W);

  logic             load;
  logic [W*H-1:0]   q;
  logic             sample;
  logic             busy;
  logic             done;
  logic [POP_W-1:0] population;
  logic             extinct;
  logic             still;
  logic             osc2;
  logic             overrun;
  logic [GEN_W-1:0] gen_count;
  logic [RW-1:0]    bbox_rmin;
  logic [RW-1:0]    bbox_rmax;
  logic [CW-1:0]    bbox_cmin;
  logic [CW-1:0]    bbox_cmax;

  modport master (
    output load, q, sample,
    input  busy, done, population, extinct, still, osc2, overrun, gen_count,
           bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax
  );

  modport slave (
    input  load, q, sample,
    output busy, done, population, extinct, still, osc2, overrun, gen_count,
           bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax
  );
endinterface

// File: rtl/life_monitor.sv
// -----------------------------------------------------------------------------
// life_monitor
//   Row-serial statistics engine for a WxH toroidal Game-of-Life grid.
//   A sample request snapshots the grid. The engine then walks the snapshot
//   one row per cycle and reports the population, extinction, still-life and
//   period-2 oscillation status, a saturating generation count and, when
//   built in, the bounding box of the live cells.
//
//   Ports
//     clk    : single clock, rising edge
//     reset  : synchronous, active-high; clears every register
//     bus    : life_monitor_if.slave
//              in  load, q, sample
//              out busy, done, population, extinct, still, osc2, overrun,
//                  gen_count, bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax
//
//   Build option
//     LIFE_MONITOR_BBOX_EN : when defined, the bounding box is tracked during
//                            the scan. Otherwise the four bbox outputs are 0.
// -----------------------------------------------------------------------------
module life_monitor #(
  parameter int W     = 16,
  parameter int H     = 16,
  parameter int GEN_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  life_monitor_if.slave bus
);
  localparam int POP_W = $clog2(W * H + 1);
  localparam int RW    = $clog2(H);
  localparam int CW    = $clog2(W);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [W*H-1:0]   snap;
  logic [W*H-1:0]   prev1;
  logic [W*H-1:0]   prev2;
  logic [RW-1:0]    row;
  logic [POP_W-1:0] acc;
  logic             eq1;
  logic             eq2;
  logic [1:0]       hist;

  // Registered outputs
  logic             busy;
  logic             done;
  logic [POP_W-1:0] population;
  logic             extinct;
  logic             still;
  logic             osc2;
  logic             overrun;
  logic [GEN_W-1:0] gen_count;

  function automatic logic [POP_W-1:0] popcount(input logic [W-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < W; i++) cnt = cnt + POP_W'(v[i]);
    return cnt;
  endfunction

  // Per-row datapath: the current row together with the same row of the two
  // previous completed snapshots, folded into the running values.
  logic [W-1:0]     cur_row;
  logic [W-1:0]     p1_row;
  logic [W-1:0]     p2_row;
  logic [POP_W-1:0] acc_next;
  logic             eq1_next;
  logic             eq2_next;
  logic             last_row;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (here unconditionally) so no latch can be inferred.
  always_comb begin
    cur_row  = snap[row*W +: W];
    p1_row   = prev1[row*W +: W];
    p2_row   = prev2[row*W +: W];
    acc_next = acc + popcount(cur_row);
    eq1_next = eq1 & (cur_row == p1_row);
    eq2_next = eq2 & (cur_row == p2_row);
    last_row = (row == RW'(H - 1));
  end

`ifdef LIFE_MONITOR_BBOX_EN
  logic          found;
  logic [RW-1:0] rmin_acc;
  logic [RW-1:0] rmax_acc;
  logic [W-1:0]  or_acc;
  logic [RW-1:0] rmin_next;
  logic [RW-1:0] rmax_next;
  logic [W-1:0]  or_next;
  logic [CW-1:0] cmin_next;
  logic [CW-1:0] cmax_next;
  logic [RW-1:0] bbox_rmin;
  logic [RW-1:0] bbox_rmax;
  logic [CW-1:0] bbox_cmin;
  logic [CW-1:0] bbox_cmax;

  // Rows arrive in ascending order: the first live row is the minimum and the
  // latest live row is the maximum. An empty grid never updates them, so they
  // stay at their capture value of 0, and an all-zero OR mask leaves the
  // column search at 0 as well.
  always_comb begin
    rmin_next = (!found && (|cur_row)) ? row : rmin_acc;
    rmax_next = (|cur_row) ? row : rmax_acc;
    or_next   = or_acc | cur_row;
    cmin_next = '0;
    cmax_next = '0;
    for (int i = W - 1; i >= 0; i--) if (or_next[i]) cmin_next = CW'(i);
    for (int i = 0; i < W; i++)      if (or_next[i]) cmax_next = CW'(i);
  end

  assign bus.bbox_rmin = bbox_rmin;
  assign bus.bbox_rmax = bbox_rmax;
  assign bus.bbox_cmin = bbox_cmin;
  assign bus.bbox_cmax = bbox_cmax;
`else
  assign bus.bbox_rmin = '0;
  assign bus.bbox_rmax = '0;
  assign bus.bbox_cmin = '0;
  assign bus.bbox_cmax = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the snapshot and history stores are cleared on reset as well,
      // because the reset state of every register is observable behaviour.
      state      <= IDLE;
      snap       <= '0;
      prev1      <= '0;
      prev2      <= '0;
      row        <= '0;
      acc        <= '0;
      eq1        <= 1'b0;
      eq2        <= 1'b0;
      hist       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      population <= '0;
      extinct    <= 1'b0;
      still      <= 1'b0;
      osc2       <= 1'b0;
      overrun    <= 1'b0;
      gen_count  <= '0;
`ifdef LIFE_MONITOR_BBOX_EN
      found      <= 1'b0;
      rmin_acc   <= '0;
      rmax_acc   <= '0;
      or_acc     <= '0;
      bbox_rmin  <= '0;
      bbox_rmax  <= '0;
      bbox_cmin  <= '0;
      bbox_cmax  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (bus.load) begin
        // New pattern loaded into the core: history is meaningless, any scan
        // in flight is dropped and a concurrent sample is not accepted.
        hist      <= '0;
        gen_count <= '0;
        state     <= IDLE;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.sample) begin
              snap      <= bus.q;
              row       <= '0;
              acc       <= '0;
              eq1       <= 1'b1;
              eq2       <= 1'b1;
              gen_count <= (&gen_count) ? gen_count : gen_count + GEN_W'(1);
              state     <= SCAN;
              busy      <= 1'b1;
`ifdef LIFE_MONITOR_BBOX_EN
              found     <= 1'b0;
              rmin_acc  <= '0;
              rmax_acc  <= '0;
              or_acc    <= '0;
`endif
            end
          end
          SCAN: begin
            if (bus.sample) overrun <= 1'b1;
            acc <= acc_next;
            eq1 <= eq1_next;
            eq2 <= eq2_next;
            row <= row + RW'(1);
`ifdef LIFE_MONITOR_BBOX_EN
            found    <= found | (|cur_row);
            rmin_acc <= rmin_next;
            rmax_acc <= rmax_next;
            or_acc   <= or_next;
`endif
            if (last_row) begin
              population <= acc_next;
              extinct    <= (acc_next == '0);
              // hist is the pre-increment count of completed snapshots.
              still      <= eq1_next && (hist >= 2'd1);
              osc2       <= eq2_next && !eq1_next && (hist >= 2'd2);
              prev2      <= prev1;
              prev1      <= snap;
              hist       <= (hist == 2'd2) ? 2'd2 : hist + 2'd1;
              done       <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
`ifdef LIFE_MONITOR_BBOX_EN
              bbox_rmin  <= rmin_next;
              bbox_rmax  <= rmax_next;
              bbox_cmin  <= cmin_next;
              bbox_cmax  <= cmax_next;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.population = population;
  assign bus.extinct    = extinct;
  assign bus.still      = still;
  assign bus.osc2       = osc2;
  assign bus.overrun    = overrun;
  assign bus.gen_count  = gen_count;
endmodule

// File: tb/tb_life_monitor.sv
// -----------------------------------------------------------------------------
// tb_life_monitor
//   Self-checking bench for life_monitor. A reference model holds the last two
//   completed snapshots as whole grids and derives every expected result from
//   them with whole-grid arithmetic ($countones, vector equality, row/column
//   search). Build with +define+LIFE_MONITOR_BBOX_EN to expect a live bbox.
// -----------------------------------------------------------------------------
module tb_life_monitor;
  localparam int W = 16;
  localparam int H = 16;
  localparam int GEN_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;

  life_monitor_if #(.W(W), .H(H), .GEN_W(GEN_W)) bus ();

  life_monitor #(.W(W), .H(H), .GEN_W(GEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [W*H-1:0] m_prev1, m_prev2;
  int m_hist, m_gen, m_pop;
  bit m_overrun, m_still, m_osc2;
  int m_rmin, m_rmax, m_cmin, m_cmax;

  task automatic model_clear();
    m_prev1 = '0; m_prev2 = '0; m_hist = 0; m_gen = 0; m_pop = 0;
    m_overrun = 0; m_still = 0; m_osc2 = 0;
    m_rmin = 0; m_rmax = 0; m_cmin = 0; m_cmax = 0;
  endtask

  // Completes one scan of grid g in the model and produces its results.
  task automatic model_scan(input logic [W*H-1:0] g);
    logic [W-1:0] colmask;
    bit any;
    m_pop   = $countones(g);
    m_still = (m_hist >= 1) && (g == m_prev1);
    m_osc2  = (m_hist >= 2) && (g == m_prev2) && (g != m_prev1);
    colmask = '0; any = 0;
    m_rmin = 0; m_rmax = 0; m_cmin = 0; m_cmax = 0;
    for (int r = 0; r < H; r++) begin
      if (g[r*W +: W] != '0) begin
        if (!any) m_rmin = r;
        m_rmax = r;
        any = 1;
      end
      colmask = colmask | g[r*W +: W];
    end
    for (int c = W - 1; c >= 0; c--) if (colmask[c]) m_cmin = c;
    for (int c = 0; c < W; c++)      if (colmask[c]) m_cmax = c;
`ifndef LIFE_MONITOR_BBOX_EN
    m_rmin = 0; m_rmax = 0; m_cmin = 0; m_cmax = 0;
`endif
    m_prev2 = m_prev1;
    m_prev1 = g;
    if (m_hist < 2) m_hist++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W*H-1:0] rand_grid();
    logic [W*H-1:0] g;
    for (int i = 0; i < W*H/32; i++) g[i*32 +: 32] = $urandom;
    return g;
  endfunction

  // Issue one sample of grid g, scramble q during the scan, optionally
  // re-assert sample overrun_at cycles into the scan, then compare the result.
  task automatic run_scan(input logic [W*H-1:0] g, input int overrun_at, input string name);
    int edges;
    bit busy_ok;
    bus.q = g; bus.sample = 1'b1;
    step();
    bus.sample = 1'b0;
    if (m_gen < (1 << GEN_W) - 1) m_gen++;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      failures++; $display("FAIL %s_accept: busy=%b done=%b required busy=1 done=0", name, bus.busy, bus.done);
    end
    edges = 0; busy_ok = 1;
    while (bus.done !== 1'b1 && edges < 40) begin
      bus.q = rand_grid();
      bus.sample = (edges == overrun_at);
      if (edges == overrun_at) m_overrun = 1;
      step();
      bus.sample = 1'b0;
      edges++;
      if (bus.done !== 1'b1 && bus.busy !== 1'b1) busy_ok = 0;
    end
    checks++;
    if (edges + 1 != H + 1) begin
      failures++; $display("FAIL %s_latency: edges=%0d required %0d", name, edges + 1, H + 1);
      return;
    end
    model_scan(g);
    checks++;
    if (!busy_ok || bus.busy !== 1'b0) begin
      failures++; $display("FAIL %s_busy: busy during scan ok=%0d busy at done=%b required ok=1 busy=0", name, busy_ok, bus.busy);
    end
    checks++;
    if (bus.population !== m_pop || bus.extinct !== (m_pop == 0)) begin
      failures++; $display("FAIL %s_pop: pop=%0d extinct=%b required pop=%0d extinct=%b", name, bus.population, bus.extinct, m_pop, m_pop == 0);
    end
    checks++;
    if (bus.still !== m_still || bus.osc2 !== m_osc2) begin
      failures++; $display("FAIL %s_status: still=%b osc2=%b required still=%b osc2=%b", name, bus.still, bus.osc2, m_still, m_osc2);
    end
    checks++;
    if (bus.gen_count !== m_gen || bus.overrun !== m_overrun) begin
      failures++; $display("FAIL %s_gen: gen=%0d overrun=%b required gen=%0d overrun=%b", name, bus.gen_count, bus.overrun, m_gen, m_overrun);
    end
    checks++;
    if (bus.bbox_rmin !== m_rmin || bus.bbox_rmax !== m_rmax || bus.bbox_cmin !== m_cmin || bus.bbox_cmax !== m_cmax) begin
      failures++; $display("FAIL %s_bbox: r=%0d..%0d c=%0d..%0d required r=%0d..%0d c=%0d..%0d", name,
        bus.bbox_rmin, bus.bbox_rmax, bus.bbox_cmin, bus.bbox_cmax, m_rmin, m_rmax, m_cmin, m_cmax);
    end
  endtask

  task automatic pulse_load();
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    m_hist = 0; m_gen = 0;
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (bus.busy !== 0 || bus.done !== 0 || bus.population !== 0 || bus.extinct !== 0 || bus.still !== 0 ||
        bus.osc2 !== 0 || bus.overrun !== 0 || bus.gen_count !== 0 || bus.bbox_rmin !== 0 || bus.bbox_rmax !== 0 ||
        bus.bbox_cmin !== 0 || bus.bbox_cmax !== 0) begin
      failures++;
      $display("FAIL %s: busy=%b done=%b pop=%0d ext=%b still=%b osc2=%b ovr=%b gen=%0d required all zero", name,
        bus.busy, bus.done, bus.population, bus.extinct, bus.still, bus.osc2, bus.overrun, bus.gen_count);
    end
  endtask

  task automatic test_reset();
    bus.load = 0; bus.sample = 0; bus.q = '0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    model_clear();
    check_zero_outputs("reset_state");
  endtask

  task automatic test_glider();
    run_scan(256'h000200010007, -1, "glider");
    checks++;
    if (bus.population !== 5 || bus.gen_count !== 1) begin
      failures++; $display("FAIL glider_const: pop=%0d gen=%0d required pop=5 gen=1", bus.population, bus.gen_count);
    end
  endtask

  task automatic test_block();
    pulse_load();
    run_scan(256'h00030003, -1, "block1");
    run_scan(256'h00030003, -1, "block2");
    checks++;
    if (bus.still !== 1'b1 || bus.population !== 4) begin
      failures++; $display("FAIL block_still: still=%b pop=%0d required still=1 pop=4", bus.still, bus.population);
    end
  endtask

  // Consecutive run_scan calls issue each sample in the previous done cycle.
  task automatic test_back_to_back();
    pulse_load();
    run_scan(256'h0007, -1, "blinker_a");
    run_scan(256'h000200020002, -1, "blinker_b");
    run_scan(256'h0007, -1, "blinker_c");
    checks++;
    if (bus.osc2 !== 1'b1 || bus.still !== 1'b0 || bus.population !== 3) begin
      failures++; $display("FAIL blinker_osc2: osc2=%b still=%b pop=%0d required 1 0 3", bus.osc2, bus.still, bus.population);
    end
    step();
    checks++;
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL done_single_cycle: done=%b required 0", bus.done);
    end
  endtask

  task automatic test_empty();
    run_scan('0, -1, "empty1");
    run_scan('0, -1, "empty2");
    checks++;
    if (bus.extinct !== 1'b1 || bus.still !== 1'b1) begin
      failures++; $display("FAIL empty_still: extinct=%b still=%b required 1 1", bus.extinct, bus.still);
    end
  endtask

  task automatic test_overrun();
    int dones;
    run_scan(rand_grid(), 4, "overrun");
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || bus.overrun !== 1'b1) begin
      failures++; $display("FAIL overrun_sticky: extra_dones=%0d overrun=%b required 0 1", dones, bus.overrun);
    end
  endtask

  task automatic test_load_abort();
    int dones;
    logic [W*H-1:0] g;
    bus.q = rand_grid(); bus.sample = 1'b1;
    step();
    bus.sample = 1'b0;
    for (int i = 0; i < 7; i++) step();
    bus.sample = 1'b1;  // sample together with load must be ignored
    pulse_load();
    bus.sample = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.gen_count !== 0) begin
      failures++; $display("FAIL load_abort: busy=%b gen=%0d required 0 0", bus.busy, bus.gen_count);
    end
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || bus.population !== m_pop || bus.still !== m_still) begin
      failures++; $display("FAIL load_hold: dones=%0d pop=%0d required dones=0 pop=%0d", dones, bus.population, m_pop);
    end
    g = rand_grid();
    run_scan(g, -1, "after_load1");
    run_scan(g, -1, "after_load2");
    checks++;
    if (bus.still !== 1'b1 || bus.gen_count !== 2) begin
      failures++; $display("FAIL load_hist: still=%b gen=%0d required 1 2", bus.still, bus.gen_count);
    end
  endtask

  // Random grids with frequent repeats so still/osc2 paths get exercised.
  task automatic test_random();
    logic [W*H-1:0] g;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 4))
        0: g = m_prev1;
        1: g = m_prev2;
        2: g = '0;
        3: g = rand_grid() & {8{32'h0000_1111}};
        default: g = rand_grid();
      endcase
      if ($urandom_range(0, 7) == 0) pulse_load();
      run_scan(g, -1, "random");
    end
  endtask

  task automatic test_reset_mid_scan();
    int dones;
    bus.q = rand_grid(); bus.sample = 1'b1;
    step();
    bus.sample = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    check_zero_outputs("reset_mid_scan");
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++; $display("FAIL reset_no_done: dones=%0d required 0", dones);
    end
    run_scan(256'h000200010007, -1, "post_reset");
  endtask

  initial begin
    test_reset();
    test_glider();
    test_block();
    test_back_to_back();
    test_empty();
    test_overrun();
    test_load_abort();
    test_random();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
